// File: rtl/psum_buffer_if.sv
// ----------------------------------------------------------------------------
// psum_buffer_if
// Groups the partial-sum buffer's control/write inputs and its drain
// handshake into one bundle.
//   clr_psum_addr  rewind the write pointer for a new accumulation pass
//   wen_psum       write/accumulate psum_in at the write pointer
//   acc_en         1 = accumulate into the stored entry, 0 = overwrite
//   psum_in        partial sum from the PE pipeline
//   done_psum      drain request
//   psum_ready     downstream accepts psum_out
//   psum_out       drained entry
//   psum_valid     psum_out is valid
//   co_psum        last entry transferred (or empty drain acknowledged)
// master = controller/pipeline side, slave = the buffer.
// ----------------------------------------------------------------------------
interface psum_buffer_if #(
  parameter int DATA_W = 16
);
  logic              clr_psum_addr;
  logic              wen_psum;
  logic              acc_en;
  logic [DATA_W-1:0] psum_in;
  logic              done_psum;
  logic              psum_ready;
  logic [DATA_W-1:0] psum_out;
  logic              psum_valid;
  logic              co_psum;

  modport master (
    output clr_psum_addr, wen_psum, acc_en, psum_in, done_psum, psum_ready,
    input  psum_out, psum_valid, co_psum
  );

  modport slave (
    input  clr_psum_addr, wen_psum, acc_en, psum_in, done_psum, psum_ready,
    output psum_out, psum_valid, co_psum
  );
endinterface

// File: rtl/psum_buffer.sv
// ----------------------------------------------------------------------------
// psum_buffer
// Stores partial sums from the PE pipeline, accumulating across passes when
// the controller re-walks the same addresses, and drains all valid entries
// over a valid/ready handshake when asked.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       psum_buffer_if.slave (write controls, drain handshake, co_psum)
//   count     number of valid entries (registered)
//   full      count == DEPTH (registered)
//   overflow  sticky: a write was dropped because the buffer was full;
//             cleared by clr_psum_addr
// ----------------------------------------------------------------------------
module psum_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic               clk,
  input  logic               rst,
  psum_buffer_if.slave       bus,
  output logic [AW:0]        count,
  output logic               full,
  output logic               overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0]   ZERO_C  = {(AW+1){1'b0}};
  localparam logic [AW:0]   ONE_C   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] RD_ONE_C = {{(AW-1){1'b0}}, 1'b1};

  // Registered state
  state_t            state_r;
  logic [AW:0]       wr_ptr_r;      // may reach DEPTH, hence AW+1 bits
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              full_r;
  logic              overflow_r;
  logic              empty_done_r;  // one-cycle acknowledge of a drain with nothing stored
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Next-state values
  state_t            state_s;
  logic [AW:0]       wr_ptr_s;
  logic [AW-1:0]     rd_ptr_s;
  logic [AW:0]       count_s;
  logic              overflow_s;
  logic              empty_done_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [AW-1:0]     wr_idx_s;
  logic              last_s;
  logic              co_final_s;

  // Next-state, datapath and handshake decode for the fill/drain FSM
  always_comb begin
    state_s      = state_r;
    wr_ptr_s     = wr_ptr_r;
    rd_ptr_s     = rd_ptr_r;
    count_s      = count_r;
    overflow_s   = overflow_r;
    empty_done_s = 1'b0;
    mem_we_s     = 1'b0;
    wr_idx_s     = wr_ptr_r[AW-1:0];
    mem_wdata_s  = bus.psum_in;
    co_final_s   = 1'b0;
    // Final transfer is when the entry being presented is the last valid one.
    last_s       = ({1'b0, rd_ptr_r} == (count_r - ONE_C));

    case (state_r)
      IDLE, FILL: begin
        // A rewind wins over a same-cycle write; that write is silently lost.
        if (bus.clr_psum_addr) begin
          wr_ptr_s   = ZERO_C;
          overflow_s = 1'b0;
        end else if (bus.wen_psum) begin
          // wr_ptr never runs ahead of count, so these three cases are exhaustive.
          if (wr_ptr_r < count_r) begin
            mem_we_s    = 1'b1;
            mem_wdata_s = bus.acc_en ? (mem_r[wr_idx_s] + bus.psum_in) : bus.psum_in;
            wr_ptr_s    = wr_ptr_r + ONE_C;
          end else if (wr_ptr_r < DEPTH_C) begin
            // Fresh entry holds no data, so acc_en is irrelevant here.
            mem_we_s    = 1'b1;
            mem_wdata_s = bus.psum_in;
            wr_ptr_s    = wr_ptr_r + ONE_C;
            count_s     = count_r + ONE_C;
          end else begin
            overflow_s = 1'b1;
          end
        end else begin
          wr_ptr_s = wr_ptr_r;
        end

        // Drain decision uses the post-write count so a same-cycle write is included.
        if (bus.done_psum) begin
          if (count_s != ZERO_C) begin
            state_s  = DRAIN;
            rd_ptr_s = {AW{1'b0}};
          end else begin
            state_s      = IDLE;
            empty_done_s = 1'b1;
          end
        end else if (count_s != ZERO_C) begin
          state_s = FILL;
        end else begin
          state_s = IDLE;
        end
      end

      DRAIN: begin
        // psum_valid is constantly high here, so a transfer is just psum_ready.
        if (bus.psum_ready) begin
          if (last_s) begin
            co_final_s = 1'b1;
            state_s    = IDLE;
            count_s    = ZERO_C;
            wr_ptr_s   = ZERO_C;
            rd_ptr_s   = {AW{1'b0}};
          end else begin
            rd_ptr_s = rd_ptr_r + RD_ONE_C;
          end
        end else begin
          rd_ptr_s = rd_ptr_r;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, pointers, counters and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      wr_ptr_r     <= ZERO_C;
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= ZERO_C;
      full_r       <= 1'b0;
      overflow_r   <= 1'b0;
      empty_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      wr_ptr_r     <= wr_ptr_s;
      rd_ptr_r     <= rd_ptr_s;
      count_r      <= count_s;
      full_r       <= (count_s == DEPTH_C);
      overflow_r   <= overflow_s;
      empty_done_r <= empty_done_s;
    end
  end

  // Entry storage; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wr_idx_s] <= mem_wdata_s;
    end
  end

  assign bus.psum_valid = (state_r == DRAIN);
  assign bus.psum_out   = mem_r[rd_ptr_r];
  assign bus.co_psum    = co_final_s | empty_done_r;
  assign count          = count_r;
  assign full           = full_r;
  assign overflow       = overflow_r;

endmodule

// File: tb/tb_psum_buffer.sv
// ----------------------------------------------------------------------------
// tb_psum_buffer
// Directed stimulus with hand-computed expected drain data pushed into a
// scoreboard queue; an independent monitor pops and compares on every
// transfer and also watches co_psum and stall stability.
// ----------------------------------------------------------------------------
module tb_psum_buffer;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic          clk;
  logic          rst;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;

  int vectors;
  int errors;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t exp_q[$];
  int   exp_empty_co;

  psum_buffer_if #(.DATA_W(DATA_W)) bus ();

  psum_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count    (count),
    .full     (full),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [DATA_W-1:0] d, input logic acc);
    bus.wen_psum = 1'b1;
    bus.psum_in  = d;
    bus.acc_en   = acc;
    step();
    bus.wen_psum = 1'b0;
  endtask

  task automatic clear();
    bus.clr_psum_addr = 1'b1;
    step();
    bus.clr_psum_addr = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic last);
    exp_t e;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Request a drain with ready held high and wait (bounded) until it ends.
  task automatic drain_all(input string name);
    int n;
    bus.psum_ready = 1'b1;
    bus.done_psum  = 1'b1;
    step();
    bus.done_psum  = 1'b0;
    n = 0;
    while (bus.psum_valid && n < 40) begin
      step();
      n++;
    end
    check({name, "_timeout"}, int'(bus.psum_valid), 0);
    check({name, "_q_empty"}, exp_q.size(), 0);
    check({name, "_count0"}, int'(count), 0);
  endtask

  // Monitor: compares every transfer against the scoreboard and checks co_psum/stalls.
  initial begin
    logic              held_v;
    logic [DATA_W-1:0] held_d;
    exp_t              e;
    held_v = 1'b0;
    held_d = '0;
    forever begin
      @(negedge clk);
      if (held_v && bus.psum_valid) begin
        check("stall_stable", int'(bus.psum_out), int'(held_d));
      end
      if (bus.psum_valid && bus.psum_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("psum_out", int'(bus.psum_out), int'(e.data));
          check("co_psum_xfer", int'(bus.co_psum), int'(e.last));
        end
      end else if (bus.co_psum) begin
        if (exp_empty_co > 0) begin
          exp_empty_co--;
          check("co_psum_empty", int'(bus.co_psum), 1);
        end else begin
          check("co_psum_spurious", int'(bus.co_psum), 0);
        end
      end
      held_v = bus.psum_valid && !bus.psum_ready;
      held_d = bus.psum_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] pat;
    vectors = 0;
    errors  = 0;
    exp_empty_co = 0;
    rst = 1'b1;
    bus.clr_psum_addr = 1'b0;
    bus.wen_psum      = 1'b0;
    bus.acc_en        = 1'b0;
    bus.psum_in       = '0;
    bus.done_psum     = 1'b0;
    bus.psum_ready    = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_valid", int'(bus.psum_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_co", int'(bus.co_psum), 0);

    // Plain writes then drain
    write(16'd5, 1'b0);
    write(16'd7, 1'b0);
    write(16'd9, 1'b0);
    check("t1_count", int'(count), 3);
    push(16'd5, 1'b0); push(16'd7, 1'b0); push(16'd9, 1'b1);
    drain_all("t1");

    // Accumulate pass: 1,2,3 then +10,+20,+30
    write(16'd1, 1'b0); write(16'd2, 1'b0); write(16'd3, 1'b0);
    clear();
    check("t2_count_clr", int'(count), 3);
    write(16'd10, 1'b1); write(16'd20, 1'b1); write(16'd30, 1'b1);
    check("t2_count", int'(count), 3);
    push(16'd11, 1'b0); push(16'd22, 1'b0); push(16'd33, 1'b1);
    drain_all("t2");

    // Second pass longer than the first: entry 3 is fresh, not accumulated
    write(16'd1, 1'b0); write(16'd2, 1'b0); write(16'd3, 1'b0);
    clear();
    write(16'd5, 1'b1); write(16'd5, 1'b1); write(16'd5, 1'b1); write(16'd7, 1'b1);
    check("t3_count", int'(count), 4);
    push(16'd6, 1'b0); push(16'd7, 1'b0); push(16'd8, 1'b0); push(16'd7, 1'b1);
    drain_all("t3");

    // Accumulate wraps modulo 2^16
    write(16'hFFF0, 1'b0);
    clear();
    write(16'h0020, 1'b1);
    push(16'h0010, 1'b1);
    drain_all("t_wrap");

    // Overflow: DEPTH+2 writes
    for (int i = 0; i < DEPTH; i++) write(16'(i + 1), 1'b0);
    check("t4_full", int'(full), 1);
    check("t4_ovf_pre", int'(overflow), 0);
    write(16'd100, 1'b0);
    write(16'd101, 1'b0);
    check("t4_overflow", int'(overflow), 1);
    check("t4_count", int'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) push(16'(i + 1), (i == DEPTH - 1));
    drain_all("t4");
    check("t4_full_after", int'(full), 0);
    clear();
    check("t4_ovf_clr", int'(overflow), 0);

    // Drain with stalling ready
    write(16'd40, 1'b0); write(16'd41, 1'b0); write(16'd42, 1'b0); write(16'd43, 1'b0);
    push(16'd40, 1'b0); push(16'd41, 1'b0); push(16'd42, 1'b0); push(16'd43, 1'b1);
    bus.done_psum = 1'b1;
    step();
    bus.done_psum = 1'b0;
    pat = 7'b1011001; // bit i = ready in drain cycle i: 1,0,0,1,1,0,1
    for (int i = 0; i < 7; i++) begin
      bus.psum_ready = pat[i];
      step();
    end
    bus.psum_ready = 1'b1;
    check("t5_valid_done", int'(bus.psum_valid), 0);
    check("t5_q_empty", exp_q.size(), 0);

    // Same-cycle write and drain request: write is included
    write(16'd4, 1'b0);
    push(16'd4, 1'b0); push(16'd8, 1'b1);
    bus.wen_psum  = 1'b1;
    bus.psum_in   = 16'd8;
    bus.acc_en    = 1'b0;
    bus.done_psum = 1'b1;
    step();
    bus.wen_psum  = 1'b0;
    bus.done_psum = 1'b0;
    check("t7_valid", int'(bus.psum_valid), 1);
    step();
    step();
    check("t7_q_empty", exp_q.size(), 0);

    // Empty drain: single-cycle co_psum, no valid
    exp_empty_co = 1;
    bus.done_psum = 1'b1;
    step();
    bus.done_psum = 1'b0;
    check("t6_co", int'(bus.co_psum), 1);
    check("t6_valid", int'(bus.psum_valid), 0);
    step();
    check("t6_co_gone", int'(bus.co_psum), 0);
    check("t6_consumed", exp_empty_co, 0);

    // Reset mid-drain
    write(16'd50, 1'b0); write(16'd51, 1'b0);
    bus.psum_ready = 1'b0;
    bus.done_psum  = 1'b1;
    step();
    bus.done_psum  = 1'b0;
    check("t8_valid_pre", int'(bus.psum_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t8_valid", int'(bus.psum_valid), 0);
    check("t8_count", int'(count), 0);
    check("t8_co", int'(bus.co_psum), 0);
    bus.psum_ready = 1'b1;
    step();
    check("t8_co_after", int'(bus.co_psum), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/psum_buffer.md
# psum_buffer

Partial-sum buffer sitting directly downstream of the main control unit and the PE pipeline. It stores pipeline partial sums written under `wen_psum` and accumulates them across passes when the control unit re-walks the same addresses. On `done_psum` it drains all valid entries to the output port over a valid/ready handshake. It returns `co_psum` on the final transfer so the controller can leave its WRITE state.

## Interface
- `DATA_W`, 16, partial-sum width.
- `DEPTH`, 16, number of entries.
- `AW`, 4, address width; DEPTH ≤ 2^AW.

- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr_psum_addr`  in  1  rewind write pointer to 0 for a new accumulation pass.
- `wen_psum`  in  1  write/accumulate `psum_in` at write pointer.
- `acc_en`  in  1  1 = add to stored entry, 0 = overwrite.
- `psum_in`  in  DATA_W  partial sum from pipeline.
- `done_psum`  in  1  drain request.
- `psum_ready`  in  1  downstream accepts `psum_out`.
- `psum_out`  out  DATA_W  drained entry, `mem[rd_ptr]`.
- `psum_valid`  out  1  `psum_out` valid.
- `co_psum`  out  1  last entry transferred this cycle (combinational).
- `count`  out  AW+1  number of valid entries.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky, a write was dropped.

## Operation
- States:
  - IDLE: empty, count = 0.
  - FILL: ≥1 valid entry.
  - DRAIN: streaming out.
- Reset: state IDLE; wr_ptr, rd_ptr and count = 0; `overflow` = 0; `psum_valid` = 0; `co_psum` = 0. Memory contents are not reset.
- Write (IDLE/FILL, `wen_psum` = 1, `clr_psum_addr` = 0):
  - wr_ptr < count, acc_en = 1: mem[wr_ptr] ← mem[wr_ptr] + psum_in, modulo 2^DATA_W, no saturation.
  - wr_ptr < count, acc_en = 0: mem[wr_ptr] ← psum_in.
  - wr_ptr == count < DEPTH: mem[wr_ptr] ← psum_in and count + 1, regardless of `acc_en`, because the entry holds no valid data.
  - wr_ptr == DEPTH: write dropped, `overflow` ← 1.
  - Otherwise wr_ptr + 1. The first write in IDLE moves the state to FILL.
- `clr_psum_addr` (IDLE/FILL): wr_ptr ← 0 and `overflow` ← 0; count is kept. It has priority over a same-cycle `wen_psum`; that write is dropped and not flagged.
- `done_psum` in IDLE/FILL:
  - count > 0: enter DRAIN with rd_ptr = 0.
  - count == 0: `co_psum` = 1 for exactly the next cycle; stay IDLE.
- Same-cycle `wen_psum` + `done_psum`: the write completes first and is included in the drain.
- DRAIN:
  - `psum_valid` = 1 and `psum_out` = mem[rd_ptr], held stable while `psum_ready` = 0.
  - Each cycle with `psum_valid` & `psum_ready`: rd_ptr + 1.
  - On the transfer where rd_ptr == count − 1, `co_psum` = 1 that cycle. Next state is IDLE with count, wr_ptr and rd_ptr = 0.
  - `wen_psum`, `clr_psum_addr` and `done_psum` are ignored in DRAIN.
- `rst` mid-drain: immediate return to IDLE next edge; `psum_valid` drops; no `co_psum`.

## Timing
- Write and accumulate: result visible in mem and `count` one cycle after the sampling edge. Back-to-back writes every cycle are supported.
- Accumulate read-modify-write is single-cycle. Consecutive writes to the same address cannot occur because wr_ptr always advances.
- Drain: first `psum_valid` in the cycle after `done_psum` is sampled. Throughput is 1 entry/cycle with `psum_ready` held high, so N entries take N + 1 cycles from request to IDLE.
- `co_psum` is a one-cycle pulse and is never high outside the final-transfer cycle or the empty-drain cycle.
- `full` and `count` are registered; `psum_out`/`psum_valid` are a combinational read of registered state.

## Test plan
- Reset, then write 5, 7, 9 with acc_en = 0 and drain with ready held high -> count = 3; outputs 5, 7, 9 on consecutive cycles; `co_psum` with 9 only; count = 0 after.
- Write 1, 2, 3; `clr_psum_addr`; write 10, 20, 30 with acc_en = 1; drain -> 11, 22, 33; count stays 3 throughout.
- Second pass with 4 writes over count = 3 and acc_en = 1 -> entry 3 overwritten with new value; count = 4.
- DEPTH + 2 writes -> `full` = 1 after DEPTH writes, `overflow` = 1, count = DEPTH; drain returns exactly DEPTH entries.
- Drain of 4 entries with `psum_ready` toggling 1,0,0,1,1,0,1 -> `psum_out` stable during stalls; values in order; `co_psum` on the 7th cycle only.
- `done_psum` with count = 0 -> single-cycle `co_psum`, `psum_valid` never high. `rst` asserted mid-drain -> `psum_valid` = 0 next cycle, count = 0, no `co_psum`.
